// File: rtl/rib_arbiter.sv
// rib_arbiter: shares one memory port between the data port and the instruction-fetch port.
// Data wins ties, but only STARVE_MAX times in a row while fetch is waiting. A granted
// transaction that never sees slave ready is abandoned after TIMEOUT cycles with an err_o pulse.
module rib_arbiter #(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  // Data port
  input  logic          d_req_i,
  input  logic          d_we_i,
  input  logic [AW-1:0] d_addr_i,
  input  logic [DW-1:0] d_wdata_i,
  output logic [DW-1:0] d_rdata_o,
  output logic          d_ready_o,
  // Fetch port
  input  logic          i_req_i,
  input  logic [AW-1:0] i_addr_i,
  output logic [DW-1:0] i_rdata_o,
  output logic          i_ready_o,
  // Shared memory port
  output logic          m_req_o,
  output logic          m_we_o,
  output logic [AW-1:0] m_addr_o,
  output logic [DW-1:0] m_wdata_o,
  input  logic [DW-1:0] m_rdata_i,
  input  logic          m_ready_i,
  // Status
  output logic          hold_o,
  output logic          err_o
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StGntD = 2'd1,
    StGntI = 2'd2
  } state_e;

  localparam logic [3:0] StarveMax = 4'(STARVE_MAX);
  // The wait counter holds cycles already spent, so the last permitted cycle is TIMEOUT-1.
  localparam logic [7:0] WaitLast  = 8'(TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [3:0] starve_q, starve_d;
  logic [7:0] wait_q, wait_d;

  logic gnt_req;
  logic in_grant;
  logic pick_d;
  logic pick_i;
  logic timeout_hit;

  // Request level of whichever master currently owns the shared port.
  always_comb begin
    gnt_req = 1'b0;
    case (state_q)
      StGntD:  gnt_req = d_req_i;
      StGntI:  gnt_req = i_req_i;
      default: gnt_req = 1'b0;
    endcase
  end

  assign in_grant = (state_q == StGntD) || (state_q == StGntI);

  // Data has priority unless fetch is waiting and data has already won StarveMax times.
  assign pick_d = d_req_i & (~i_req_i | (starve_q < StarveMax));
  assign pick_i = ~pick_d & i_req_i;

  // Ready in the same cycle always wins over the timeout.
  assign timeout_hit = in_grant & gnt_req & ~m_ready_i & (wait_q == WaitLast);

  // Next-state: arbitrate from idle, leave a grant on ready, request drop or timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (pick_d) begin
          state_d = StGntD;
        end else if (pick_i) begin
          state_d = StGntI;
        end
      end
      StGntD, StGntI: begin
        if (m_ready_i || !gnt_req || timeout_hit) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Starvation counter: counts data grants taken while fetch was waiting.
  always_comb begin
    starve_d = starve_q;
    if (state_q == StIdle) begin
      if (!i_req_i) begin
        starve_d = '0;
      end
      if (pick_d && i_req_i) begin
        starve_d = (starve_q >= StarveMax) ? StarveMax : starve_q + 4'd1;
      end else if (pick_i) begin
        starve_d = '0;
      end
    end
  end

  // Wait counter: cleared on grant entry, counts grant cycles without slave ready.
  always_comb begin
    wait_d = wait_q;
    if (state_q == StIdle) begin
      if (pick_d || pick_i) begin
        wait_d = '0;
      end
    end else if (in_grant && !m_ready_i) begin
      wait_d = wait_q + 8'd1;
    end
  end

  // State and counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      starve_q <= '0;
      wait_q   <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      wait_q   <= wait_d;
    end
  end

  // Shared-port mux and ready routing; everything is zero while idle.
  always_comb begin
    m_req_o   = 1'b0;
    m_we_o    = 1'b0;
    m_addr_o  = '0;
    m_wdata_o = '0;
    d_ready_o = 1'b0;
    i_ready_o = 1'b0;
    case (state_q)
      StGntD: begin
        m_req_o   = d_req_i;
        m_we_o    = d_we_i;
        m_addr_o  = d_addr_i;
        m_wdata_o = d_wdata_i;
        d_ready_o = m_ready_i;
      end
      StGntI: begin
        m_req_o   = i_req_i;
        m_addr_o  = i_addr_i;
        i_ready_o = m_ready_i;
      end
      default: ;
    endcase
  end

  assign d_rdata_o = m_rdata_i;
  assign i_rdata_o = m_rdata_i;

  // Stall execute until its data access completes; forced low while reset is asserted.
  assign hold_o = rst_ni & d_req_i & ~((state_q == StGntD) & m_ready_i);

  assign err_o = timeout_hit;

endmodule

// File: tb/tb_rib_arbiter.sv
// Bench for rib_arbiter: directed vector table, hand-written corner sequences,
// then randomized masters/slave checked against a transaction-level model.
module tb_rib_arbiter;

  localparam int unsigned StarveP  = 4;
  localparam int unsigned TimeoutP = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        d_req, d_we, i_req, m_ready;
  logic [31:0] d_addr, d_wdata, i_addr, m_rdata;
  logic [31:0] d_rdata, i_rdata, m_addr, m_wdata;
  logic        d_ready, i_ready, m_req, m_we, hold, err;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: who owns the port, for how long, and how many
  // data wins in a row fetch has had to sit through.
  int owner;    // 0 nobody, 1 data master, 2 fetch master
  int waited;
  int d_wins;
  bit last_dr, last_ir;

  rib_arbiter #(
    .AW        (32),
    .DW        (32),
    .STARVE_MAX(StarveP),
    .TIMEOUT   (TimeoutP)
  ) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .d_req_i  (d_req),
    .d_we_i   (d_we),
    .d_addr_i (d_addr),
    .d_wdata_i(d_wdata),
    .d_rdata_o(d_rdata),
    .d_ready_o(d_ready),
    .i_req_i  (i_req),
    .i_addr_i (i_addr),
    .i_rdata_o(i_rdata),
    .i_ready_o(i_ready),
    .m_req_o  (m_req),
    .m_we_o   (m_we),
    .m_addr_o (m_addr),
    .m_wdata_o(m_wdata),
    .m_rdata_i(m_rdata),
    .m_ready_i(m_ready),
    .hold_o   (hold),
    .err_o    (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        i_req;
    logic [31:0] i_addr;
    logic        m_ready;
    logic [31:0] m_rdata;
    logic [69:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [69:0] pack(input logic rq, input logic we, input logic [31:0] a,
                                       input logic [31:0] wd, input logic dr, input logic ir,
                                       input logic h, input logic e);
    return {rq, we, a, wd, dr, ir, h, e};
  endfunction

  function automatic logic [69:0] dut_out();
    return {m_req, m_we, m_addr, m_wdata, d_ready, i_ready, hold, err};
  endfunction

  function automatic vec_t mk(input logic dr, input logic dwe, input logic [31:0] da,
                              input logic [31:0] dwd, input logic ir, input logic [31:0] ia,
                              input logic mr, input logic [31:0] md, input logic [69:0] e);
    vec_t v;
    v.d_req = dr; v.d_we = dwe; v.d_addr = da; v.d_wdata = dwd;
    v.i_req = ir; v.i_addr = ia; v.m_ready = mr; v.m_rdata = md; v.exp = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Wait for the next edge, then apply a full input set just after it.
  task automatic drive(input logic dr, input logic dwe, input logic [31:0] da,
                       input logic [31:0] dwd, input logic ir, input logic [31:0] ia,
                       input logic mr, input logic [31:0] md);
    @(posedge clk);
    #1;
    d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd;
    i_req = ir; i_addr = ia; m_ready = mr; m_rdata = md;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    #1;
    rst_n = 1'b0;
    d_req = 1; d_we = 1; d_addr = 32'h1234; d_wdata = 32'h5678;
    i_req = 1; i_addr = 32'h9abc; m_ready = 1; m_rdata = 32'h0bad_f00d;
    #3;
    check("reset_outputs", dut_out(), '0);
    check("reset_rdata", {d_rdata, i_rdata}, {m_rdata, m_rdata});
    repeat (2) @(posedge clk);
    #1;
    check("reset_across_edge", dut_out(), '0);
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    i_req = 0; i_addr = 0; m_ready = 0; m_rdata = 0;
    @(negedge clk);
    rst_n = 1'b1;
    owner = 0; waited = 0; d_wins = 0; last_dr = 0; last_ir = 0;
  endtask

  // One cycle of the reference model: predict outputs from the current inputs,
  // compare, then advance ownership for the coming edge.
  task automatic ref_cycle();
    bit          own_req, exp_dr, exp_ir, exp_err;
    logic [31:0] exp_a, exp_wd;
    own_req = (owner == 1) ? d_req : (owner == 2) ? i_req : 1'b0;
    exp_a   = (owner == 1) ? d_addr : (owner == 2) ? i_addr : 32'h0;
    exp_wd  = (owner == 1) ? d_wdata : 32'h0;
    exp_dr  = (owner == 1) && m_ready;
    exp_ir  = (owner == 2) && m_ready;
    exp_err = (owner != 0) && own_req && !m_ready && (waited + 1 == int'(TimeoutP));
    check("rand_outputs", dut_out(),
          pack(own_req, (owner == 1) && d_we, exp_a, exp_wd, exp_dr, exp_ir,
               d_req && !exp_dr, exp_err));
    check("rand_rdata", {d_rdata, i_rdata}, {m_rdata, m_rdata});
    if (owner == 0) begin
      if (!i_req) d_wins = 0;
      if (d_req && (!i_req || d_wins < int'(StarveP))) begin
        owner = 1; waited = 0;
        if (i_req) d_wins++;
      end else if (i_req) begin
        owner = 2; waited = 0; d_wins = 0;
      end
    end else if (m_ready || !own_req || exp_err) begin
      owner = 0;
    end else begin
      waited++;
    end
    last_dr = exp_dr;
    last_ir = exp_ir;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running, expected finished");
    $fatal(1);
  end

  initial begin
    bit     d_pend, i_pend;
    int     rdy_pct;
    logic [69:0] idle_z, idle_h, gnt_d3, gnt_i2;

    // Lone fetch
    tbl.push_back(mk(0, 0, 0, 0, 1, 'h100, 0, 0, pack(0, 0, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(mk(0, 0, 0, 0, 1, 'h100, 0, 0, pack(1, 0, 'h100, 0, 0, 0, 0, 0)));
    tbl.push_back(mk(0, 0, 0, 0, 1, 'h100, 1, 'h13, pack(1, 0, 'h100, 0, 0, 1, 0, 0)));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, pack(0, 0, 0, 0, 0, 0, 0, 0)));
    // Simultaneous requests: data first, fetch after one idle cycle
    tbl.push_back(mk(1, 1, 'h2000, 'hDEADBEEF, 1, 'h104, 0, 0, pack(0, 0, 0, 0, 0, 0, 1, 0)));
    tbl.push_back(mk(1, 1, 'h2000, 'hDEADBEEF, 1, 'h104, 0, 0,
                     pack(1, 1, 'h2000, 'hDEADBEEF, 0, 0, 1, 0)));
    tbl.push_back(mk(1, 1, 'h2000, 'hDEADBEEF, 1, 'h104, 1, 'h55,
                     pack(1, 1, 'h2000, 'hDEADBEEF, 1, 0, 0, 0)));
    tbl.push_back(mk(0, 0, 0, 0, 1, 'h104, 0, 0, pack(0, 0, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(mk(0, 0, 0, 0, 1, 'h104, 1, 'hCAFE, pack(1, 0, 'h104, 0, 0, 1, 0, 0)));
    // Ready while idle is ignored
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 'h77, pack(0, 0, 0, 0, 0, 0, 0, 0)));
    // Starvation: four data grants, then fetch, then data again
    idle_h = pack(0, 0, 0, 0, 0, 0, 1, 0);
    gnt_d3 = pack(1, 0, 'h3000, 'h11111111, 1, 0, 0, 0);
    gnt_i2 = pack(1, 0, 'h200, 0, 0, 1, 1, 0);
    idle_z = pack(0, 0, 0, 0, 0, 0, 0, 0);
    tbl.push_back(mk(1, 0, 'h3000, 'h11111111, 1, 'h200, 1, 1, idle_h));
    tbl.push_back(mk(1, 0, 'h3000, 'h11111111, 1, 'h200, 1, 2, gnt_d3));
    tbl.push_back(mk(1, 0, 'h3000, 'h11111111, 1, 'h200, 1, 3, idle_h));
    tbl.push_back(mk(1, 0, 'h3000, 'h11111111, 1, 'h200, 1, 4, gnt_d3));
    tbl.push_back(mk(1, 0, 'h3000, 'h11111111, 1, 'h200, 1, 5, idle_h));
    tbl.push_back(mk(1, 0, 'h3000, 'h11111111, 1, 'h200, 1, 6, gnt_d3));
    tbl.push_back(mk(1, 0, 'h3000, 'h11111111, 1, 'h200, 1, 7, idle_h));
    tbl.push_back(mk(1, 0, 'h3000, 'h11111111, 1, 'h200, 1, 8, gnt_d3));
    tbl.push_back(mk(1, 0, 'h3000, 'h11111111, 1, 'h200, 1, 9, idle_h));
    tbl.push_back(mk(1, 0, 'h3000, 'h11111111, 1, 'h200, 1, 10, gnt_i2));
    tbl.push_back(mk(1, 0, 'h3000, 'h11111111, 1, 'h200, 1, 11, idle_h));
    tbl.push_back(mk(1, 0, 'h3000, 'h11111111, 1, 'h200, 1, 12, gnt_d3));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, idle_z));

    do_reset();

    foreach (tbl[i]) begin
      drive(tbl[i].d_req, tbl[i].d_we, tbl[i].d_addr, tbl[i].d_wdata,
            tbl[i].i_req, tbl[i].i_addr, tbl[i].m_ready, tbl[i].m_rdata);
      check($sformatf("vec%0d_outputs", i), dut_out(), tbl[i].exp);
      check($sformatf("vec%0d_rdata", i), {d_rdata, i_rdata}, {m_rdata, m_rdata});
    end

    // Timeout: fetch granted, slave silent; err in the 8th grant cycle only
    drive(0, 0, 0, 0, 1, 'h300, 0, 0);
    check("to_idle", m_req, 0);
    for (int k = 1; k <= 8; k++) begin
      drive(0, 0, 0, 0, 1, 'h300, 0, 0);
      check($sformatf("to_grant%0d", k), {m_req, i_ready, err}, {1'b1, 1'b0, k == 8});
    end
    drive(0, 0, 0, 0, 1, 'h300, 0, 0);
    check("to_back_idle", {m_req, i_ready, err}, 3'b000);
    drive(0, 0, 0, 0, 1, 'h300, 0, 0);
    check("to_regrant", {m_req, m_addr}, {1'b1, 32'h300});
    drive(0, 0, 0, 0, 1, 'h300, 1, 'h42);
    check("to_complete", {i_ready, err, i_rdata}, {1'b1, 1'b0, 32'h42});
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    // Request dropped before ready: back to idle, no ready pulse
    drive(1, 0, 'h400, 0, 0, 0, 0, 0);
    check("drop_idle", m_req, 0);
    drive(1, 0, 'h400, 0, 0, 0, 0, 0);
    check("drop_grant", {m_req, m_addr}, {1'b1, 32'h400});
    drive(0, 0, 'h400, 0, 0, 0, 0, 0);
    check("drop_cycle", {m_req, d_ready, hold}, 3'b000);
    drive(1, 0, 'h400, 0, 0, 0, 1, 0);
    check("drop_then_idle", {m_req, d_ready, hold}, 3'b001);
    drive(1, 0, 'h400, 0, 0, 0, 0, 0);
    check("drop_regrant", m_req, 1);
    drive(1, 0, 'h400, 0, 0, 0, 1, 0);
    check("drop_complete", {d_ready, hold}, 2'b10);
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    // Reset asserted mid-grant acts immediately; pending request re-arbitrated after
    drive(1, 1, 'h500, 'hA5, 0, 0, 0, 0);
    check("rst_pre_idle", m_req, 0);
    drive(1, 1, 'h500, 'hA5, 0, 0, 0, 0);
    check("rst_pre_grant", {m_req, hold}, 2'b11);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async", dut_out(), '0);
    @(posedge clk);
    #2;
    check("rst_held", dut_out(), '0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_released", {m_req, hold}, 2'b01);
    @(posedge clk);
    #2;
    check("rst_rearb", {m_req, m_we, m_addr, m_wdata}, {1'b1, 1'b1, 32'h500, 32'hA5});
    drive(1, 1, 'h500, 'hA5, 0, 0, 1, 0);
    check("rst_complete", {d_ready, hold}, 2'b10);
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    // Randomized masters and slave against the reference model
    do_reset();
    d_pend = 0;
    i_pend = 0;
    for (int c = 0; c < 4000; c++) begin
      rdy_pct = (c < 2000) ? 40 : 12;
      @(posedge clk);
      #1;
      if (last_dr) d_pend = 0;
      if (last_ir) i_pend = 0;
      if (!d_pend) begin
        d_we    = 1'($urandom_range(0, 1));
        d_addr  = $urandom;
        d_wdata = $urandom;
        d_pend  = ($urandom_range(0, 2) == 0);
      end
      if (!i_pend) begin
        i_addr = $urandom;
        i_pend = ($urandom_range(0, 2) == 0);
      end
      d_req   = d_pend;
      i_req   = i_pend;
      m_ready = ($urandom_range(0, 99) < rdy_pct);
      m_rdata = $urandom;
      #1;
      ref_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
